// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks a one-hot column drive, debounces press and release
// of the first key found, and hands the decoded code to a valid/ack consumer.
module keypad_scanner #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int DB_CYCLES = 20000,
  parameter int HEX_MAP   = 1,
  localparam int KW = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ROWS-1:0] rows_in,
  output logic [COLS-1:0] cols_out,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ack,
  output logic            key_held,
  output logic            overrun
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DB_CYCLES + 1);

  localparam logic [3:0] HEX_LUT [16] = '{
    4'h1, 4'h2, 4'h3, 4'hC,
    4'h4, 4'h5, 4'h6, 4'hD,
    4'h7, 4'h8, 4'h9, 4'hE,
    4'hA, 4'h0, 4'hB, 4'hF
  };

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

  state_t          state_reg;
  logic [ROWS-1:0] sync1_reg;
  logic [ROWS-1:0] rs_reg;
  logic [CW-1:0]   col_reg;
  logic [COLS-1:0] cols_reg;
  logic [RW-1:0]   row_reg;
  logic [SW-1:0]   scan_cnt_reg;
  logic [DW-1:0]   db_cnt_reg;
  logic [KW-1:0]   key_code_reg;
  logic            key_valid_reg;
  logic            key_held_reg;
  logic            overrun_reg;

  logic [RW-1:0]   low_row;
  logic [CW-1:0]   col_next;
  logic [COLS-1:0] col_next_oh;
  logic            row_bit;
  logic [KW-1:0]   lin_code;
  logic [KW-1:0]   decode_code;

  // Lowest-index asserted row wins when several are pressed together.
  always_comb begin
    low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (rs_reg[i]) low_row = RW'(i);
    end
  end

  assign row_bit  = rs_reg[row_reg];
  assign col_next = (col_reg == CW'(COLS - 1)) ? '0 : col_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col_oh
      assign col_next_oh[gi] = (col_next == CW'(gi));
    end
  endgenerate

  always_comb begin
    lin_code = KW'(int'(row_reg) * COLS + int'(col_reg));
  end

  generate
    if (HEX_MAP != 0) begin : g_hex
      assign decode_code = KW'(HEX_LUT[lin_code]);
    end else begin : g_lin
      assign decode_code = lin_code;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= SCAN;
      sync1_reg     <= '0;
      rs_reg        <= '0;
      col_reg       <= '0;
      cols_reg      <= COLS'(1);
      row_reg       <= '0;
      scan_cnt_reg  <= '0;
      db_cnt_reg    <= '0;
      key_code_reg  <= '0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      sync1_reg <= rows_in;
      rs_reg    <= sync1_reg;

      // An emission in the same cycle overrides this clear.
      if (key_valid_reg && key_ack) key_valid_reg <= 1'b0;

      case (state_reg)
        SCAN: begin
          if (rs_reg != '0) begin
            row_reg      <= low_row;
            db_cnt_reg   <= '0;
            scan_cnt_reg <= '0;
            state_reg    <= PRESS_DB;
          end else if (scan_cnt_reg == SW'(SCAN_DIV - 1)) begin
            scan_cnt_reg <= '0;
            col_reg      <= col_next;
            cols_reg     <= col_next_oh;
          end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
          end
        end
        PRESS_DB: begin
          if (!row_bit) begin
            db_cnt_reg <= '0;
            state_reg  <= SCAN;
          end else if (db_cnt_reg == DW'(DB_CYCLES - 1)) begin
            db_cnt_reg   <= '0;
            state_reg    <= HELD;
            key_held_reg <= 1'b1;
            if (!key_valid_reg || key_ack) begin
              key_code_reg  <= decode_code;
              key_valid_reg <= 1'b1;
            end else begin
              overrun_reg <= 1'b1;
            end
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
        HELD: begin
          if (!row_bit) begin
            db_cnt_reg <= '0;
            state_reg  <= REL_DB;
          end
        end
        REL_DB: begin
          if (row_bit) begin
            db_cnt_reg <= '0;
            state_reg  <= HELD;
          end else if (db_cnt_reg == DW'(DB_CYCLES - 1)) begin
            db_cnt_reg   <= '0;
            state_reg    <= SCAN;
            key_held_reg <= 1'b0;
            col_reg      <= col_next;
            cols_reg     <= col_next_oh;
            scan_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= SCAN;
      endcase
    end
  end

  assign cols_out  = cols_reg;
  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: scan walk, press/release debounce, glitch
// rejection, overrun and ack-reload handling, reset while a key is held.
module tb_keypad_scanner;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KW   = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [ROWS-1:0] rows_in = '0;
  logic [COLS-1:0] cols_out;
  logic [KW-1:0]   key_code;
  logic            key_valid;
  logic            key_ack = 1'b0;
  logic            key_held;
  logic            overrun;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(3), .DB_CYCLES(4), .HEX_MAP(1)
  ) dut (
    .clk(clk), .reset(reset), .rows_in(rows_in), .cols_out(cols_out),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .key_held(key_held), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cols"},  32'(cols_out),  32'h1);
    check({tag, "_valid"}, 32'(key_valid), 32'h0);
    check({tag, "_code"},  32'(key_code),  32'h0);
    check({tag, "_held"},  32'(key_held),  32'h0);
    check({tag, "_ovr"},   32'(overrun),   32'h0);
  endtask

  task automatic wait_col(input logic [COLS-1:0] mask);
    int n = 0;
    while (cols_out !== mask && n < 100) begin
      tick();
      n++;
    end
    check("wait_col", 32'(cols_out), 32'(mask));
  endtask

  // Rows rise right after the column becomes driven; acceptance lands 7 cycles later.
  task automatic press(input logic [ROWS-1:0] rows, input logic ack_at_emit);
    rows_in = rows;
    for (int i = 0; i < 6; i++) tick();
    check("press_not_yet_held", 32'(key_held), 32'h0);
    key_ack = ack_at_emit;
    tick();
    key_ack = 1'b0;
    check("press_held", 32'(key_held), 32'h1);
    $display("press rows=%b cols=%b -> code=%h valid=%b overrun=%b",
             rows, cols_out, key_code, key_valid, overrun);
  endtask

  task automatic release_clean();
    rows_in = '0;
    for (int i = 0; i < 6; i++) tick();
    check("rel_still_held", 32'(key_held), 32'h1);
    tick();
    check("rel_done", 32'(key_held), 32'h0);
    $display("release -> held=%b cols=%b", key_held, cols_out);
  endtask

  initial begin
    // Reset values
    reset = 1'b1;
    tick();
    tick();
    check_reset_state("reset");
    $display("reset -> cols=%b valid=%b", cols_out, key_valid);

    // Column walk, 3 cycles per column, no key
    do_reset();
    for (int k = 0; k < 13; k++) begin
      check("scan_walk", 32'(cols_out), 32'(1 << ((k / 3) % 4)));
      tick();
    end
    $display("scan walk of 13 cycles done");

    // Row2 while col1 driven -> '8' after 7 cycles
    do_reset();
    wait_col(4'b0010);
    rows_in = 4'b0100;
    for (int i = 0; i < 6; i++) tick();
    check("lat_valid_early", 32'(key_valid), 32'h0);
    tick();
    check("lat_valid", 32'(key_valid), 32'h1);
    check("lat_code", 32'(key_code), 32'h8);
    check("lat_held", 32'(key_held), 32'h1);
    check("lat_cols_frozen", 32'(cols_out), 32'h2);
    $display("press row2/col1 -> code=%h valid=%b", key_code, key_valid);
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    check("ack_clears", 32'(key_valid), 32'h0);
    check("ack_code_kept", 32'(key_code), 32'h8);

    // Release bounce: low 2, high 1, low 4
    rows_in = '0;
    tick();
    tick();
    rows_in = 4'b0100;
    tick();
    rows_in = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bounce_held", 32'(key_held), 32'h1);
    end
    tick();
    check("bounce_released", 32'(key_held), 32'h0);
    check("bounce_next_col", 32'(cols_out), 32'h4);
    check("bounce_no_valid", 32'(key_valid), 32'h0);
    $display("release bounce -> held=%b cols=%b", key_held, cols_out);

    // Two-cycle glitch on row0 during press debounce
    do_reset();
    rows_in = 4'b0001;
    tick();
    tick();
    rows_in = '0;
    for (int i = 0; i < 3; i++) tick();
    check("glitch_cols", 32'(cols_out), 32'h1);
    check("glitch_valid", 32'(key_valid), 32'h0);
    check("glitch_held", 32'(key_held), 32'h0);
    for (int i = 0; i < 3; i++) tick();
    check("glitch_rescan", 32'(cols_out), 32'h2);
    check("glitch_valid_late", 32'(key_valid), 32'h0);
    $display("glitch row0 -> valid=%b cols=%b", key_valid, cols_out);

    // Overrun: second press without ack, then a press with ack at emission
    do_reset();
    wait_col(4'b0001);
    press(4'b0001, 1'b0);
    check("ovr_first_code", 32'(key_code), 32'h1);
    check("ovr_first_valid", 32'(key_valid), 32'h1);
    check("ovr_not_yet", 32'(overrun), 32'h0);
    release_clean();
    wait_col(4'b0010);
    press(4'b0010, 1'b0);
    check("ovr_set", 32'(overrun), 32'h1);
    check("ovr_code_kept", 32'(key_code), 32'h1);
    check("ovr_valid_kept", 32'(key_valid), 32'h1);
    release_clean();
    wait_col(4'b0100);
    press(4'b1000, 1'b1);
    check("reload_code", 32'(key_code), 32'hB);
    check("reload_valid", 32'(key_valid), 32'h1);
    check("reload_ovr_sticky", 32'(overrun), 32'h1);

    // Reset while held
    reset = 1'b1;
    tick();
    check_reset_state("held_reset");
    rows_in = '0;
    reset = 1'b0;
    $display("reset in HELD -> cols=%b held=%b", cols_out, key_held);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
